time_counter_bcd: RTL and testbench
===================================

Name: time_counter_bcd

Overview:
Time-keeping core of the digital clock. It sits directly downstream of the 50 MHz-to-1 Hz divider and consumes its 1 Hz square wave. It counts seconds, minutes and hours in packed BCD (24-hour format) and supports manual minute/hour adjustment and pause. It also emits a one-second strobe and an on-the-hour chime pulse for the display and beeper stages.

Parameters:
HOUR_MOD, 24, hour modulus; hours count 00..HOUR_MOD-1. Only 24 and 12 are legal; with 12, hours count 00..11.

Ports:
clk_50M  input   1  system clock, 50 MHz; every flop sits on the rising edge
ncr      input   1  reset, synchronous, active-low
clk_1    input   1  1 Hz square wave from the divider, registered in the clk_50M domain
en       input   1  count enable; 1 = run, 0 = pause
adj_min  input   1  minute adjust, debounced level; each rising edge adds one minute
adj_hour input   1  hour adjust, debounced level; each rising edge adds one hour
sec_bcd  output  8  seconds; [7:4] tens, [3:0] units
min_bcd  output  8  minutes; [7:4] tens, [3:0] units
hour_bcd output  8  hours; [7:4] tens, [3:0] units
tick_1s  output  1  one-cycle pulse in the cycle sec_bcd first shows a new count value
chime    output  1  one-cycle pulse in the cycle a natural 59:59 -> 00:00 rollover becomes visible

Behaviour:
- Reset (ncr=0 at a clk_50M edge):
  - sec_bcd, min_bcd and hour_bcd clear to 8'h00; tick_1s and chime clear to 0.
  - Each edge-detect history flop loads the current value of its input (clk_1, adj_min, adj_hour). No spurious tick or adjust occurs on the first cycle after release, even if an input is high.
- Edge detect: tick = clk_1 & ~clk_1_d. Define am = adj_min & ~adj_min_d and ah = adj_hour & ~adj_hour_d, each with its own history flop.
- Latency: clk_1 is first sampled high at edge k. At edge k+1 the outputs show the updated time and tick_1s=1. At edge k+2 tick_1s returns to 0.
- Seconds:
  - On tick & en: units+1. Units 9 -> 0 carries into tens. 59 -> 00 raises the internal carry cs.
  - tick_1s = registered (tick & en).
- Minutes:
  - Increment amount is cs + am (0, 1 or 2), applied modulo 60 in BCD. For example, 58 + 2 -> 00 and 59 + 2 -> 01.
  - A minute carry cm is raised only when the cs path crosses 59 -> 00. An adjust-caused wrap never carries into hours.
  - When cs=am=1 at 59: the result is 01 and cm=1.
- Hours:
  - Increment amount is cm + ah, applied modulo HOUR_MOD in BCD.
  - For 24: 23 -> 00 and 09 -> 10. With both cm and ah, 22 -> 00.
- Chime: registered, equal to 1 exactly when cm=1 in the same update. It is never raised by am or ah.
- en=0: ticks are discarded, not queued, and tick_1s stays 0. Adjusts remain active while paused.
- Adjust does not modify seconds.
- BCD invariants: units never exceed 9; sec/min tens never exceed 5; hour never exceeds HOUR_MOD-1. No illegal code is reachable from reset.
- Reset mid-operation: the synchronous clear overrides every simultaneous tick or adjust in that cycle.
- Outputs are registered and hold between updates; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset and release with clk_1=1 held high -> all outputs 8'h00; no tick_1s for 10 cycles; the first tick_1s comes one cycle after the next clk_1 0 -> 1.
2. Preset 23:59 by pulsing adj_hour 23 times and adj_min 59 times, then give 59 clk_1 rising edges -> 23:59:59 with 59 tick_1s pulses. The next clk_1 edge -> 00:00:00 with tick_1s=1 and chime=1 in the same single cycle.
3. At 12:59:30, one adj_min rising edge -> 12:00:30; chime=0; hour unchanged; seconds unchanged.
4. At 10:59:59, drive the clk_1 rise and the adj_min rise so their edges are detected in the same cycle -> 11:01:00 and chime=1. At 22:59:59 with tick + adj_hour coincident -> 00:00:00.
5. With en=0, give 5 clk_1 edges -> time unchanged and tick_1s never asserts; adj_hour still advances 05 -> 06. Set en=1 -> counting resumes from the held value, with no burst.
6. Assert ncr=0 for one cycle at 14:37:21, coincident with a tick -> next cycle 00:00:00, tick_1s=0, chime=0.

Source files
------------

// File: rtl/time_counter_bcd.sv
// BCD seconds/minutes/hours core driven by a 1 Hz square wave, with minute/hour adjust, pause, 1 s strobe and hourly chime.
// Latency: one cycle after clk_1 is sampled high; no backpressure, outputs are registered and hold between updates.
module time_counter_bcd #(
  parameter int HOUR_MOD = 24
) (
  input  logic       clk_50M,
  input  logic       ncr,
  input  logic       clk_1,
  input  logic       en,
  input  logic       adj_min,
  input  logic       adj_hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       tick_1s,
  output logic       chime
);

  localparam logic [6:0] HMOD = 7'(HOUR_MOD);

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return {3'd0, b[7:4]} * 7'd10 + {3'd0, b[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return (8'(v / 7'd10) << 4) | 8'(v % 7'd10);
  endfunction

  logic [7:0] r_sec, r_min, r_hour;
  logic       r_tick_1s, r_chime;
  logic       r_clk_1, r_clk_1_d, r_adj_min_d, r_adj_hour_d;

  logic       w_tick, w_am, w_ah, w_sec_inc, w_cs, w_cm;
  logic [6:0] w_sec_bin, w_min_bin, w_hour_bin;
  logic [6:0] w_sec_nxt, w_min_sum, w_min_nxt, w_hour_sum, w_hour_nxt;

  // clk_1 is sampled first, so its edge is seen one cycle after the raw adjust edges.
  assign w_tick    = r_clk_1 & ~r_clk_1_d;
  assign w_am      = adj_min & ~r_adj_min_d;
  assign w_ah      = adj_hour & ~r_adj_hour_d;
  assign w_sec_inc = w_tick & en;

  assign w_sec_bin  = bcd2bin(r_sec);
  assign w_min_bin  = bcd2bin(r_min);
  assign w_hour_bin = bcd2bin(r_hour);

  assign w_cs      = w_sec_inc & (w_sec_bin == 7'd59);
  assign w_sec_nxt = w_cs ? 7'd0 : w_sec_bin + {6'd0, w_sec_inc};

  // Only the seconds carry crossing 59 can carry into hours; an adjust wrap stays local.
  assign w_cm      = w_cs & (w_min_bin == 7'd59);
  assign w_min_sum = w_min_bin + {6'd0, w_cs} + {6'd0, w_am};
  assign w_min_nxt = (w_min_sum >= 7'd60) ? w_min_sum - 7'd60 : w_min_sum;

  assign w_hour_sum = w_hour_bin + {6'd0, w_cm} + {6'd0, w_ah};
  assign w_hour_nxt = (w_hour_sum >= HMOD) ? w_hour_sum - HMOD : w_hour_sum;

  always_ff @(posedge clk_50M) begin
    if (!ncr) begin
      r_sec        <= 8'h00;
      r_min        <= 8'h00;
      r_hour       <= 8'h00;
      r_tick_1s    <= 1'b0;
      r_chime      <= 1'b0;
      r_clk_1      <= clk_1;
      r_clk_1_d    <= clk_1;
      r_adj_min_d  <= adj_min;
      r_adj_hour_d <= adj_hour;
    end else begin
      r_sec        <= bin2bcd(w_sec_nxt);
      r_min        <= bin2bcd(w_min_nxt);
      r_hour       <= bin2bcd(w_hour_nxt);
      r_tick_1s    <= w_sec_inc;
      r_chime      <= w_cm;
      r_clk_1      <= clk_1;
      r_clk_1_d    <= r_clk_1;
      r_adj_min_d  <= adj_min;
      r_adj_hour_d <= adj_hour;
    end
  end

  assign sec_bcd  = r_sec;
  assign min_bcd  = r_min;
  assign hour_bcd = r_hour;
  assign tick_1s  = r_tick_1s;
  assign chime    = r_chime;

endmodule

// File: tb/tb_time_counter_bcd.sv
// Bench for time_counter_bcd: cycle scoreboard against a behavioural clock model plus directed checks.
module tb_time_counter_bcd;
  localparam int HM = 24;

  logic       clk_50M = 1'b0;
  logic       ncr = 1'b0, clk_1 = 1'b1, en = 1'b1, adj_min = 1'b0, adj_hour = 1'b0;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic       tick_1s, chime;

  time_counter_bcd #(.HOUR_MOD(HM)) dut (
    .clk_50M(clk_50M), .ncr(ncr), .clk_1(clk_1), .en(en),
    .adj_min(adj_min), .adj_hour(adj_hour),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd),
    .tick_1s(tick_1s), .chime(chime)
  );

  always #10 clk_50M = ~clk_50M;

  int n_vec = 0, n_err = 0, n_tick = 0;
  int m_sec = 0, m_min = 0, m_hour = 0;
  bit m_tick = 0, m_chime = 0;
  bit m_c1 = 0, m_c1d = 0, m_amd = 0, m_ahd = 0;
  logic [25:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [31:0] now();
    return {8'h00, hour_bcd, min_bcd, sec_bcd};
  endfunction

  // Advance the model for the inputs now applied, push the expectation, then compare after the edge.
  task automatic step();
    bit tk, am, ah, inc, cs, cm;
    logic [25:0] e;
    if (!ncr) begin
      m_sec = 0; m_min = 0; m_hour = 0; m_tick = 0; m_chime = 0;
      m_c1 = clk_1; m_c1d = clk_1; m_amd = adj_min; m_ahd = adj_hour;
    end else begin
      tk = m_c1 && !m_c1d;
      am = adj_min && !m_amd;
      ah = adj_hour && !m_ahd;
      m_c1d = m_c1; m_c1 = clk_1; m_amd = adj_min; m_ahd = adj_hour;
      inc = tk && en;
      cs  = inc && (m_sec == 59);
      cm  = cs && (m_min == 59);
      m_sec  = cs ? 0 : m_sec + int'(inc);
      m_min  = (m_min + int'(cs) + int'(am)) % 60;
      m_hour = (m_hour + int'(cm) + int'(ah)) % HM;
      m_tick = inc; m_chime = cm;
    end
    sb.push_back({m_tick, m_chime, bcd(m_hour), bcd(m_min), bcd(m_sec)});
    @(posedge clk_50M);
    #1;
    e = sb.pop_front();
    chk("cycle", {6'd0, tick_1s, chime, hour_bcd, min_bcd, sec_bcd}, {6'd0, e});
    if (tick_1s) n_tick++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sec_edges(input int n);
    for (int i = 0; i < n; i++) begin
      clk_1 = 1'b1; steps(2);
      clk_1 = 1'b0; steps(2);
    end
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      adj_min = 1'b1; step();
      adj_min = 1'b0; step();
    end
  endtask

  task automatic pulse_hour(input int n);
    for (int i = 0; i < n; i++) begin
      adj_hour = 1'b1; step();
      adj_hour = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    clk_1 = 1'b0; adj_min = 1'b0; adj_hour = 1'b0; en = 1'b1;
    ncr = 1'b0; step();
    ncr = 1'b1; step();
  endtask

  task automatic preset(input int h, input int m, input int s);
    do_reset();
    pulse_hour(h);
    pulse_min(m);
    sec_edges(s);
  endtask

  initial begin
    // 1: reset with clk_1 held high, no spurious tick, first tick one cycle after the next rise
    steps(2);
    chk("rst_time", now(), 32'h0);
    chk("rst_flags", {30'd0, tick_1s, chime}, 32'd0);
    ncr = 1'b1;
    n_tick = 0;
    steps(10);
    chk("no_spur_tick", n_tick, 0);
    clk_1 = 1'b0; step();
    clk_1 = 1'b1; step();
    chk("tick_not_yet", {31'd0, tick_1s}, 32'd0);
    step();
    chk("first_tick", {31'd0, tick_1s}, 32'd1);
    chk("first_sec", now(), 32'h000001);
    step();
    chk("tick_one_cycle", {31'd0, tick_1s}, 32'd0);

    // 2: preset 23:59, run 59 s, then the day rollover with chime
    do_reset();
    pulse_hour(23);
    pulse_min(59);
    n_tick = 0;
    sec_edges(59);
    chk("ticks_59", n_tick, 59);
    chk("t_235959", now(), 32'h235959);
    clk_1 = 1'b1; steps(2);
    chk("t_rollover", now(), 32'h000000);
    chk("roll_flags", {30'd0, tick_1s, chime}, 32'd3);
    clk_1 = 1'b0; step();
    chk("chime_one_cycle", {31'd0, chime}, 32'd0);
    step();

    // 3: adjust wrap at 12:59:30 does not carry or chime
    preset(12, 59, 30);
    chk("t_125930", now(), 32'h125930);
    adj_min = 1'b1; step();
    chk("adj_wrap", now(), 32'h120030);
    chk("adj_no_chime", {31'd0, chime}, 32'd0);
    adj_min = 1'b0; steps(2);

    // 4: tick coincident with minute adjust, then with hour adjust
    preset(10, 59, 59);
    clk_1 = 1'b1; step();
    adj_min = 1'b1; step();
    chk("tick_am", now(), 32'h110100);
    chk("tick_am_chime", {31'd0, chime}, 32'd1);
    adj_min = 1'b0; clk_1 = 1'b0; steps(2);
    preset(22, 59, 59);
    clk_1 = 1'b1; step();
    adj_hour = 1'b1; step();
    chk("tick_ah", now(), 32'h000000);
    adj_hour = 1'b0; clk_1 = 1'b0; steps(2);

    // 5: pause discards ticks, adjust still works, resume without a burst
    preset(5, 0, 0);
    en = 1'b0;
    n_tick = 0;
    sec_edges(5);
    chk("pause_ticks", n_tick, 0);
    chk("pause_time", now(), 32'h050000);
    pulse_hour(1);
    chk("pause_adj", now(), 32'h060000);
    en = 1'b1;
    steps(6);
    chk("resume_no_burst", n_tick, 0);
    sec_edges(1);
    chk("resume_time", now(), 32'h060001);
    chk("resume_ticks", n_tick, 1);

    // 6: reset coincident with a tick wins
    preset(14, 37, 21);
    chk("t_143721", now(), 32'h143721);
    clk_1 = 1'b1; step();
    ncr = 1'b0; step();
    chk("rst_mid_time", now(), 32'h000000);
    chk("rst_mid_flags", {30'd0, tick_1s, chime}, 32'd0);
    ncr = 1'b1; steps(3);
    clk_1 = 1'b0; steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
